// File: rtl/bist_pulse_seq_if.sv
// bist_pulse_seq_if: control, config and status bundle between test-start logic and the pulse sequencer
interface bist_pulse_seq_if #(parameter int CNT_W = 8);
  logic start;
  logic abort;
  logic cont;
  logic [CNT_W-1:0] n_high;
  logic [CNT_W-1:0] n_low;
  logic [CNT_W-1:0] m_reps;
  logic out;
  logic running;
  logic bist_end;
  logic [CNT_W-1:0] pulse_idx;
  modport master (
    output start, abort, cont, n_high, n_low, m_reps,
    input  out, running, bist_end, pulse_idx
  );
  modport slave (
    input  start, abort, cont, n_high, n_low, m_reps,
    output out, running, bist_end, pulse_idx
  );
endinterface

// File: rtl/bist_pulse_seq.sv
// bist_pulse_seq: programmable BIST pulse-burst generator with continuous mode, abort and pulse index
module bist_pulse_seq #(
  parameter int   CNT_W   = 8,
  parameter logic OUT_POL = 1'b1
) (
  input logic clk,
  input logic reset,
  bist_pulse_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [1:0] state_q, state_d;
  logic start_q, start_d;
  logic cont_q, cont_d;
  logic [CNT_W-1:0] n_high_q, n_high_d;
  logic [CNT_W-1:0] n_low_q, n_low_d;
  logic [CNT_W-1:0] m_reps_q, m_reps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic out_q, out_d;
  logic running_q, running_d;
  logic bist_end_q, bist_end_d;
  logic launch, last, degenerate;
  logic [CNT_W-1:0] idx_next;
  assign start_d    = bus.start;
  assign launch     = bus.start & ~start_q;
  assign degenerate = (bus.n_high == '0) || (bus.m_reps == '0);
  assign last       = idx_q == m_reps_q - ONE;
  assign idx_next   = last ? '0 : idx_q + ONE;
  assign bus.out       = out_q;
  assign bus.running   = running_q;
  assign bus.bist_end  = bist_end_q;
  assign bus.pulse_idx = idx_q;
  // next-state: launch from IDLE/DONE, phase sequencing and abort in HIGH/LOW
  always_comb begin
    state_d    = state_q;
    cont_d     = cont_q;
    n_high_d   = n_high_q;
    n_low_d    = n_low_q;
    m_reps_d   = m_reps_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    out_d      = out_q;
    running_d  = running_q;
    bist_end_d = bist_end_q;
    case (state_q)
      HIGH, LOW: begin
        cnt_d = cnt_q + ONE;
        if (bus.abort) begin
          state_d    = IDLE;
          cnt_d      = '0;
          idx_d      = '0;
          out_d      = ~OUT_POL;
          running_d  = 1'b0;
          bist_end_d = 1'b0;
        end else if (state_q == HIGH && cnt_q == n_high_q - ONE) begin
          cnt_d = '0;
          if (last && !cont_q) begin
            state_d    = DONE;
            out_d      = ~OUT_POL;
            running_d  = 1'b0;
            bist_end_d = 1'b1;
          end else if (n_low_q != '0) begin
            state_d = LOW;
            out_d   = ~OUT_POL;
          end else
            idx_d = idx_next;
        end else if (state_q == LOW && cnt_q == n_low_q - ONE) begin
          state_d = HIGH;
          cnt_d   = '0;
          idx_d   = idx_next;
          out_d   = OUT_POL;
        end
      end
      default: begin
        if (launch) begin
          cont_d     = bus.cont;
          n_high_d   = bus.n_high;
          n_low_d    = bus.n_low;
          m_reps_d   = bus.m_reps;
          cnt_d      = '0;
          idx_d      = '0;
          state_d    = degenerate ? DONE : HIGH;
          out_d      = degenerate ? ~OUT_POL : OUT_POL;
          running_d  = ~degenerate;
          bist_end_d = degenerate;
        end
      end
    endcase
  end
  // state and output registers; start edge register resets high to block a held start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b1;
      cont_q     <= 1'b0;
      n_high_q   <= '0;
      n_low_q    <= '0;
      m_reps_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      out_q      <= ~OUT_POL;
      running_q  <= 1'b0;
      bist_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      cont_q     <= cont_d;
      n_high_q   <= n_high_d;
      n_low_q    <= n_low_d;
      m_reps_q   <= m_reps_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      out_q      <= out_d;
      running_q  <= running_d;
      bist_end_q <= bist_end_d;
    end
  end
endmodule

// File: tb/tb_bist_pulse_seq.sv
// tb_bist_pulse_seq: directed plus random checks of bist_pulse_seq against a burst-timing model
module tb_bist_pulse_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  bist_pulse_seq_if #(.CNT_W(8)) bus();
  bist_pulse_seq #(.CNT_W(8), .OUT_POL(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int n_vec = 0;
  int n_err = 0;
  int ph = 0;
  int k = 0;
  int c_nh = 0, c_nl = 0, c_m = 0;
  bit c_cont = 1'b0;
  bit st_prev = 1'b1;
  int run_cnt = 0, pulse_cnt = 0;
  logic out_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic set_cfg(input int nh, input int nl, input int m, input bit c);
    bus.n_high = 8'(nh);
    bus.n_low  = 8'(nl);
    bus.m_reps = 8'(m);
    bus.cont   = c;
  endtask

  task automatic step();
    bit l, act;
    int p, t_len, ei;
    logic eo, er, eb;
    l = bus.start && !st_prev;
    act = ph == 1 && c_nh > 0 && c_m > 0 && (c_cont || k < c_m * c_nh + (c_m - 1) * c_nl);
    @(posedge clk);
    if (reset) begin
      ph = 0;
      st_prev = 1'b1;
    end else begin
      if (act) begin
        if (bus.abort) ph = 0;
        else k++;
      end else if (l) begin
        ph = 1;
        k = 0;
        c_nh = int'(bus.n_high);
        c_nl = int'(bus.n_low);
        c_m = int'(bus.m_reps);
        c_cont = bus.cont;
      end else if (ph == 1) k++;
      st_prev = bus.start;
    end
    #1;
    eo = 1'b0; er = 1'b0; eb = 1'b0; ei = 0;
    if (ph == 1) begin
      if (c_nh == 0 || c_m == 0) eb = 1'b1;
      else begin
        p = c_nh + c_nl;
        t_len = c_m * c_nh + (c_m - 1) * c_nl;
        if (!c_cont && k >= t_len) begin
          eb = 1'b1;
          ei = c_m - 1;
        end else begin
          eo = (k % p) < c_nh;
          er = 1'b1;
          ei = (k / p) % c_m;
        end
      end
    end
    chk("out", 32'(bus.out), 32'(eo));
    chk("running", 32'(bus.running), 32'(er));
    chk("bist_end", 32'(bus.bist_end), 32'(eb));
    chk("pulse_idx", 32'(bus.pulse_idx), 32'(ei));
    if (bus.running === 1'b1) run_cnt++;
    if (bus.out === 1'b1 && out_prev !== 1'b1) pulse_cnt++;
    out_prev = bus.out;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic launch_edge();
    bus.start = 1'b0;
    run(1);
    bus.start = 1'b1;
  endtask

  initial begin
    bus.start = 1'b1;
    bus.abort = 1'b0;
    set_cfg(8, 1, 9, 0);
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(3);
    launch_edge();
    run_cnt = 0;
    pulse_cnt = 0;
    run(3);
    bus.start = 1'b0;
    run(1);
    bus.start = 1'b1;
    set_cfg(2, 2, 2, 1);
    run(81);
    chk("legacy_running_cycles", 32'(run_cnt), 32'd80);
    chk("legacy_pulse_count", 32'(pulse_cnt), 32'd9);
    set_cfg(3, 0, 4, 0);
    launch_edge();
    run(16);
    bus.abort = 1'b1;
    run(2);
    bus.abort = 1'b0;
    set_cfg(4, 2, 0, 0);
    launch_edge();
    run(4);
    set_cfg(0, 2, 3, 0);
    launch_edge();
    run(4);
    set_cfg(2, 2, 3, 1);
    launch_edge();
    run(17);
    bus.abort = 1'b1;
    run(1);
    bus.abort = 1'b0;
    run(3);
    set_cfg(8, 1, 9, 0);
    launch_edge();
    run(12);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(2);
    launch_edge();
    run_cnt = 0;
    pulse_cnt = 0;
    run(85);
    chk("reset_rerun_running_cycles", 32'(run_cnt), 32'd80);
    chk("reset_rerun_pulse_count", 32'(pulse_cnt), 32'd9);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 6 == 0) bus.start = ~bus.start;
      bus.abort = ($urandom % 25 == 0);
      reset = ($urandom % 200 == 0);
      if ($urandom % 4 == 0) set_cfg($urandom % 5, $urandom % 4, $urandom % 5, 1'($urandom % 2));
      run(1);
    end
    reset = 1'b0;
    bus.abort = 1'b0;
    run(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bist_pulse_seq.md
Name: bist_pulse_seq

Overview:
Parametrised successor to the fixed N=8/M=9 BIST pulse controller. Generates a burst of M pulses, each N_HIGH cycles active followed by N_LOW cycles inactive, with all three counts programmable at run time. Adds a continuous mode, an abort input and pulse-index visibility. Sits between the test-start logic and the circuit under BIST; it drives the stimulus pulse and the running / bist_end status.

Parameters:
CNT_W, 8, width of the n_high, n_low and m_reps config inputs, the internal counters and pulse_idx.
OUT_POL, 1, active level of out; the inactive level is ~OUT_POL.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  level input; a rising edge, sampled on clk, launches a run.
abort  input  1  synchronous abort; terminates a run in progress.
cont  input  1  mode select, latched at launch: 0 = single burst, 1 = continuous.
n_high  input  CNT_W  active cycles per pulse, latched at launch.
n_low  input  CNT_W  inactive cycles between pulses, latched at launch.
m_reps  input  CNT_W  pulses per burst, latched at launch.
out  output  1  pulse output, registered.
running  output  1  high while a burst is active, registered.
bist_end  output  1  high after a single-mode burst completes, registered.
pulse_idx  output  CNT_W  0-based index of the current pulse, registered.

Behaviour:
- Reset:
  - state=IDLE; out=~OUT_POL; running=0; bist_end=0; pulse_idx=0.
  - The start edge register resets to 1, so a start held high through reset does not launch a run.
- Edge detect: start_q <= start on every clk. A launch occurs when start=1 and start_q=0.
- States: IDLE, HIGH, LOW, DONE. All outputs are registered and change on the launching edge (no extra latency).
- IDLE / DONE, on launch:
  - Latch cont, n_high, n_low and m_reps.
  - Clear bist_end and pulse_idx.
  - If n_high==0 or m_reps==0, go to DONE with bist_end=1. out never asserts.
  - Otherwise go to HIGH with out=OUT_POL and running=1.
- HIGH: out active for exactly n_high cycles. At the end of the last HIGH cycle:
  - If this is not the last pulse (pulse_idx != m_reps-1):
    - With n_low>0, go to LOW.
    - With n_low==0, go to HIGH again; pulse_idx increments and out stays active.
  - If this is the last pulse and cont=0, go to DONE: out inactive, running=0, bist_end=1.
  - If this is the last pulse and cont=1, wrap: pulse_idx=0 and the burst restarts after an n_low gap (or immediately if n_low==0). bist_end is never set in continuous mode.
- LOW:
  - out inactive for exactly n_low cycles.
  - Then go to HIGH and increment pulse_idx.
  - No LOW phase follows the final pulse of a single burst.
- DONE: bist_end is held at 1 until a new launch or reset.
- abort=1 in HIGH or LOW:
  - Next state is IDLE: out inactive, running=0, bist_end=0, pulse_idx=0.
  - abort in IDLE or DONE has no effect.
  - abort has priority over a simultaneous launch.
- Ignored inputs:
  - A start edge while in HIGH or LOW is ignored and does not retrigger.
  - Config inputs changing mid-run have no effect.
- Counters:
  - The phase counter is CNT_W bits and counts 0..len-1.
  - Maximum lengths are 2^CNT_W-1 per phase and 2^CNT_W-1 pulses. No wrap occurs within a phase.
- reset asserted mid-run aborts the run to the reset state on the same edge. reset has priority over all inputs.

Test Plan:
- Legacy config: n_high=8, n_low=1, m_reps=9, cont=0, start edge at edge E0. Required response:
  - out high for 8 cycles, low for 1, repeated; 9 pulses total.
  - running=1 for 80 cycles.
  - At E80: bist_end=1, running=0, out=0.
  - pulse_idx steps 0..8.
- Back-to-back pulses: n_high=3, n_low=0, m_reps=4 -> out high continuously for 12 cycles, then DONE.
- Degenerate config: m_reps=0 (or n_high=0) -> bist_end=1 one cycle after launch, out never high, running stays 0.
- Continuous mode: cont=1, n_high=2, n_low=2, m_reps=3 -> pulse_idx sequence 0,1,2,0,1,... running stays 1 and bist_end stays 0. abort on cycle 17 -> out=0, running=0 on the next edge.
- Start handling:
  - start held high across reset release -> no launch.
  - A second start edge during HIGH -> ignored, so the pulse count is unchanged.
  - A start edge in DONE -> bist_end clears and a new burst runs.
- Mid-burst reset: reset pulse during pulse 2 of the legacy config -> all outputs return to reset values on that edge, and the next launch produces a full 9-pulse burst.
